cache_axi_rd_arbiter: RTL and testbench

//  Merges the I-cache and D-cache AXI read-request/read-data channels onto one AXI master AR/R port.

---
 rtl/cache_axi_rd_arbiter_if.sv | 49 ++++
 rtl/cache_axi_rd_arbiter.sv | 100 ++++++++++
 tb/tb_cache_axi_rd_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_rd_arbiter_if.sv
// Bundle of I-cache, D-cache and AXI master read-channel signals seen by the read arbiter.
// The slave modport is the arbiter's view; the master modport is the caches-plus-bus side.
interface cache_axi_rd_arbiter_if #(
  parameter int ID_WIDTH = 4
);
  logic [31:0]         i_araddr;
  logic [7:0]          i_arlen;
  logic                i_arvalid;
  logic                i_arready;
  logic                i_rvalid;
  logic                i_rready;
  logic [31:0]         d_araddr;
  logic [7:0]          d_arlen;
  logic                d_arvalid;
  logic                d_arready;
  logic                d_rvalid;
  logic                d_rready;
  logic [31:0]         s_rdata;
  logic                s_rlast;
  logic [ID_WIDTH-1:0] m_arid;
  logic [31:0]         m_araddr;
  logic [7:0]          m_arlen;
  logic [2:0]          m_arsize;
  logic [1:0]          m_arburst;
  logic                m_arvalid;
  logic                m_arready;
  logic [31:0]         m_rdata;
  logic                m_rlast;
  logic                m_rvalid;
  logic                m_rready;

  modport slave (
    input  i_araddr, i_arlen, i_arvalid, i_rready,
    input  d_araddr, d_arlen, d_arvalid, d_rready,
    input  m_arready, m_rdata, m_rlast, m_rvalid,
    output i_arready, i_rvalid, d_arready, d_rvalid,
    output s_rdata, s_rlast,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
  );

  modport master (
    output i_araddr, i_arlen, i_arvalid, i_rready,
    output d_araddr, d_arlen, d_arvalid, d_rready,
    output m_arready, m_rdata, m_rlast, m_rvalid,
    input  i_arready, i_rvalid, d_arready, d_rvalid,
    input  s_rdata, s_rlast,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
  );
endinterface

// File: rtl/cache_axi_rd_arbiter.sv
// Round-robin merge of I/D-cache AXI reads onto one master AR/R port, one burst in flight.
// AR issued the cycle after a request is sampled in IDLE; R backpressure is the granted cache's rready.
module cache_axi_rd_arbiter #(
  parameter int                  ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] I_ID     = '0,
  parameter logic [ID_WIDTH-1:0] D_ID     = ID_WIDTH'(1)
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_axi_rd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_gnt_q, last_gnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [ID_WIDTH-1:0] arid_q, arid_d;
  logic                rready_sel;

  // last_gnt resets to I so the first tie goes to the D-cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      arid_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      arid_q     <= arid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_gnt_d    = last_gnt_q;
    addr_d        = addr_q;
    len_d         = len_q;
    arid_d        = arid_q;
    rready_sel    = gnt_q ? bus.d_rready : bus.i_rready;
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
    bus.i_arready = 1'b0;
    bus.d_arready = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.d_rvalid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_arvalid || bus.d_arvalid) begin
          gnt_d   = (bus.i_arvalid && bus.d_arvalid) ? ~last_gnt_q : bus.d_arvalid;
          addr_d  = gnt_d ? bus.d_araddr : bus.i_araddr;
          len_d   = gnt_d ? bus.d_arlen : bus.i_arlen;
          arid_d  = gnt_d ? D_ID : I_ID;
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus.m_arvalid = 1'b1;
        if (bus.m_arready) begin
          bus.i_arready = ~gnt_q;
          bus.d_arready = gnt_q;
          last_gnt_d    = gnt_q;
          state_d       = DATA;
        end
      end
      DATA: begin
        bus.i_rvalid = ~gnt_q & bus.m_rvalid;
        bus.d_rvalid = gnt_q & bus.m_rvalid;
        bus.m_rready = rready_sel;
        if (bus.m_rvalid && rready_sel && bus.m_rlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_arid    = arid_q;
  assign bus.m_araddr  = addr_q;
  assign bus.m_arlen   = len_q;
  assign bus.m_arsize  = 3'b010;
  assign bus.m_arburst = 2'b01;
  assign bus.s_rdata   = bus.m_rdata;
  assign bus.s_rlast   = bus.m_rlast;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: the bench plays both caches and the AXI slave.
module tb_cache_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  cache_axi_rd_arbiter_if #(.ID_WIDTH(4)) v ();

  cache_axi_rd_arbiter #(.ID_WIDTH(4), .I_ID(4'd0), .D_ID(4'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    v.i_araddr  = '0; v.i_arlen = '0; v.i_arvalid = 1'b0; v.i_rready = 1'b0;
    v.d_araddr  = '0; v.d_arlen = '0; v.d_arvalid = 1'b0; v.d_rready = 1'b0;
    v.m_arready = 1'b0; v.m_rdata = '0; v.m_rlast = 1'b0; v.m_rvalid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_arvalid"}, v.m_arvalid, 1'b0);
    check({tag, "_arready"}, {v.i_arready, v.d_arready}, 2'b00);
    check({tag, "_rvalid"}, {v.i_rvalid, v.d_rvalid}, 2'b00);
    check({tag, "_rready"}, v.m_rready, 1'b0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check_idle("rst");
    check("rst_arsize", v.m_arsize, 3'b010);
    check("rst_arburst", v.m_arburst, 2'b01);
    check("rst_araddr", v.m_araddr, 32'h0);
    check("rst_arlen", v.m_arlen, 8'h0);
    check("rst_arid", v.m_arid, 4'h0);
  endtask

  // Entered in IDLE with requests already driven; returns in IDLE after the last beat.
  task automatic run_burst(input bit is_d, input logic [31:0] addr, input logic [7:0] len,
                           input int ar_delay, input int stall_beat, input int stall_cyc);
    int   beat;
    int   cyc;
    int   left;
    logic rr;
    logic [3:0] exp_id;
    exp_id = is_d ? 4'd1 : 4'd0;
    tick();
    v.m_arready = 1'b0;
    #1;
    for (int k = 0; k < ar_delay; k++) begin
      check("ar_wait_arvalid", v.m_arvalid, 1'b1);
      check("ar_wait_araddr", v.m_araddr, addr);
      check("ar_wait_arlen", v.m_arlen, len);
      check("ar_wait_arready", {v.i_arready, v.d_arready}, 2'b00);
      tick();
    end
    v.m_arready = 1'b1;
    #1;
    check("ar_arvalid", v.m_arvalid, 1'b1);
    check("ar_arid", v.m_arid, exp_id);
    check("ar_araddr", v.m_araddr, addr);
    check("ar_arlen", v.m_arlen, len);
    check("ar_pulse", {v.i_arready, v.d_arready}, is_d ? 2'b01 : 2'b10);
    tick();
    v.m_arready = 1'b0;
    if (is_d) v.d_arvalid = 1'b0;
    else      v.i_arvalid = 1'b0;
    beat = 0;
    cyc  = 0;
    left = stall_cyc;
    while (beat <= int'(len) && cyc < 300) begin
      rr = !(beat == stall_beat && left > 0);
      v.m_rvalid = 1'b1;
      v.m_rdata  = addr + 32'(beat * 4);
      v.m_rlast  = (beat == int'(len));
      if (is_d) begin v.d_rready = rr; v.i_rready = ~rr; end
      else      begin v.i_rready = rr; v.d_rready = ~rr; end
      #1;
      check("r_arready_gone", {v.i_arready, v.d_arready}, 2'b00);
      check("r_rvalid_route", {v.i_rvalid, v.d_rvalid}, is_d ? 2'b01 : 2'b10);
      check("r_m_rready", v.m_rready, rr);
      check("r_s_rdata", v.s_rdata, addr + 32'(beat * 4));
      check("r_s_rlast", v.s_rlast, beat == int'(len));
      if (rr) beat++;
      else    left--;
      cyc++;
      tick();
    end
    check("beat_count", beat, int'(len) + 1);
    v.m_rvalid = 1'b0; v.m_rlast = 1'b0; v.i_rready = 1'b0; v.d_rready = 1'b0;
    #1;
    check_idle("post");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    do_reset();

    // I-cache only, immediate AR accept
    v.i_araddr = 32'h1FC0_0000; v.i_arlen = 8'd7; v.i_arvalid = 1'b1;
    run_burst(1'b0, 32'h1FC0_0000, 8'd7, 0, -1, 0);

    // AR handshake delayed 3 cycles
    v.i_araddr = 32'h1FC0_0100; v.i_arlen = 8'd3; v.i_arvalid = 1'b1;
    run_burst(1'b0, 32'h1FC0_0100, 8'd3, 3, -1, 0);

    // D burst with the cache stalling beat 3 for 2 cycles
    v.d_araddr = 32'h8000_1000; v.d_arlen = 8'd7; v.d_arvalid = 1'b1;
    run_burst(1'b1, 32'h8000_1000, 8'd7, 0, 3, 2);

    // Uncached single-beat D read
    v.d_araddr = 32'hBFAF_8000; v.d_arlen = 8'd0; v.d_arvalid = 1'b1;
    run_burst(1'b1, 32'hBFAF_8000, 8'd0, 1, -1, 0);

    // Round robin: both pending every time, D wins first after reset
    do_reset();
    v.i_araddr = 32'h0000_1000; v.i_arlen = 8'd1; v.i_arvalid = 1'b1;
    v.d_araddr = 32'h0000_2000; v.d_arlen = 8'd1; v.d_arvalid = 1'b1;
    for (int p = 0; p < 4; p++) begin
      run_burst(1'b1, 32'h0000_2000, 8'd1, 0, -1, 0);
      v.d_arvalid = 1'b1;
      run_burst(1'b0, 32'h0000_1000, 8'd1, 0, -1, 0);
      v.i_arvalid = 1'b1;
    end
    v.i_arvalid = 1'b0;
    v.d_arvalid = 1'b0;

    // Reset during DATA beat 4 of an I burst
    v.i_araddr = 32'h0000_3000; v.i_arlen = 8'd7; v.i_arvalid = 1'b1;
    tick();
    v.m_arready = 1'b1;
    tick();
    v.m_arready = 1'b0; v.i_arvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      v.m_rvalid = 1'b1; v.m_rdata = 32'(b); v.m_rlast = 1'b0; v.i_rready = 1'b1;
      tick();
    end
    v.m_rvalid = 1'b1; v.m_rdata = 32'd4; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_idle("midrst");
    check("midrst_araddr", v.m_araddr, 32'h0);
    check("midrst_arlen", v.m_arlen, 8'h0);
    v.m_rvalid = 1'b0; v.i_rready = 1'b0;
    #1;
    v.i_araddr = 32'h1FC0_0040; v.i_arlen = 8'd3; v.i_arvalid = 1'b1;
    run_burst(1'b0, 32'h1FC0_0040, 8'd3, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
